// File: rtl/piso_pkg.sv
//------------------------------------------------------------------------------
// Module   : piso_pkg
// Summary  : Shared state type and counter-width helper for piso_stream.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package piso_pkg;

  typedef enum logic [0:0] {
    PISO_IDLE  = 1'b0,
    PISO_SHIFT = 1'b1
  } piso_state_e;

  // Bit counter must hold WIDTH-1; a 2-bit word still needs one counter bit.
  function automatic int piso_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/piso_stream.sv
//------------------------------------------------------------------------------
// Module   : piso_stream
// Summary  : Parameterised PISO with valid/ready load, shift-enable stall and
//            selectable bit order; gapless word streaming on the last bit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int               CNT_W    = piso_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             serial_valid_q, serial_valid_d;
  logic             last_q, last_d;
  logic             serial_out_q, serial_out_d;

  logic             advance;
  logic             at_last;
  logic             accept;
  logic [WIDTH-1:0] shreg_shifted;

  assign advance    = (state_q == PISO_SHIFT) && shift_en;
  assign at_last    = (cnt_q == LAST_CNT);
  // Ready depends only on state, count and shift_en, never on load_valid.
  assign load_ready = (state_q == PISO_IDLE) || (advance && at_last);
  assign accept     = load_valid && load_ready;

  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;

    if (accept) begin
      shreg_d = parallel_in;
      cnt_d   = '0;
      state_d = PISO_SHIFT;
    end else if (advance) begin
      shreg_d = shreg_shifted;
      if (at_last) begin
        cnt_d   = '0;
        state_d = PISO_IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Outputs are registered from the next-state values so they align with shreg_q.
    serial_valid_d = (state_d == PISO_SHIFT);
    last_d         = serial_valid_d && (cnt_d == LAST_CNT);
    serial_out_d   = serial_valid_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= PISO_IDLE;
      shreg_q        <= '0;
      cnt_q          <= '0;
      serial_valid_q <= 1'b0;
      last_q         <= 1'b0;
      serial_out_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      shreg_q        <= shreg_d;
      cnt_q          <= cnt_d;
      serial_valid_q <= serial_valid_d;
      last_q         <= last_d;
      serial_out_q   <= serial_out_d;
    end
  end

  assign serial_valid = serial_valid_q;
  assign serial_out   = serial_out_q;
  assign last         = last_q;
  assign busy         = serial_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_stream.sv
//------------------------------------------------------------------------------
// Module   : tb_piso_stream
// Summary  : Three piso_stream instances (W4/MSB, W4/LSB, W8/MSB) checked
//            against a bit-queue reference model plus directed scenarios.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       lv   [3];
  logic       se   [3];
  logic [7:0] pin  [3];
  logic       rdy  [3];
  logic       so   [3];
  logic       sv   [3];
  logic       lst  [3];
  logic       bsy  [3];

  int checks   = 0;
  int failures = 0;

  // Reference model: per instance, a FIFO of pending bits and their last flags.
  bit          eb [3][256];
  bit          el [3][256];
  int          rd [3];
  int          wr [3];
  logic [63:0] cap [3];
  int          run2, maxrun2;

  always #5 clk = ~clk;

  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]),
    .parallel_in(pin[0][3:0]), .shift_en(se[0]), .serial_out(so[0]),
    .serial_valid(sv[0]), .last(lst[0]), .busy(bsy[0]));

  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b0)) u_d1 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]),
    .parallel_in(pin[1][3:0]), .shift_en(se[1]), .serial_out(so[1]),
    .serial_valid(sv[1]), .last(lst[1]), .busy(bsy[1]));

  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b1)) u_d2 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(rdy[2]),
    .parallel_in(pin[2]), .shift_en(se[2]), .serial_out(so[2]),
    .serial_valid(sv[2]), .last(lst[2]), .busy(bsy[2]));

  function automatic int wof(input int d);
    return (d == 2) ? 8 : 4;
  endfunction

  function automatic bit msbof(input int d);
    return (d != 1);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      rd[d] = 0;
      wr[d] = 0;
    end
  endtask

  // Check every instance against the model, advance the model, then cross the edge.
  task automatic tick();
    #1;
    for (int d = 0; d < 3; d++) begin
      bit ev, eo, elast, er, acc, adv;
      ev    = (wr[d] != rd[d]);
      eo    = ev ? eb[d][rd[d] % 256] : 1'b0;
      elast = ev ? el[d][rd[d] % 256] : 1'b0;
      er    = !ev || (se[d] && elast);
      chk("serial_valid", d, {31'd0, sv[d]},  {31'd0, ev});
      chk("serial_out",   d, {31'd0, so[d]},  {31'd0, eo});
      chk("last",         d, {31'd0, lst[d]}, {31'd0, elast});
      chk("busy",         d, {31'd0, bsy[d]}, {31'd0, ev});
      chk("load_ready",   d, {31'd0, rdy[d]}, {31'd0, er});
      if (rst) begin
        if (sv[d] === 1'b1 && se[d]) cap[d] = {cap[d][62:0], so[d]};
        acc = lv[d] && er;
        adv = ev && se[d];
        if (adv) rd[d]++;
        if (acc) begin
          for (int i = 0; i < wof(d); i++) begin
            eb[d][wr[d] % 256] = msbof(d) ? pin[d][wof(d)-1-i] : pin[d][i];
            el[d][wr[d] % 256] = (i == wof(d) - 1);
            wr[d]++;
          end
        end
      end
    end
    run2 = (sv[2] === 1'b1) ? run2 + 1 : 0;
    if (run2 > maxrun2) maxrun2 = run2;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      lv[d] = 1'b0; se[d] = 1'b1; pin[d] = 8'h00; cap[d] = '0;
    end
    run2 = 0; maxrun2 = 0;
    model_reset();
    @(negedge clk);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Same word into MSB-first and LSB-first 4-bit instances.
    lv[0] = 1'b1; pin[0] = 8'h0B;
    lv[1] = 1'b1; pin[1] = 8'h0B;
    tick();
    lv[0] = 1'b0; lv[1] = 1'b0; pin[0] = $urandom; pin[1] = $urandom;
    repeat (4) tick();
    tick();
    chk("msb_first_bits", 0, {28'd0, cap[0][3:0]}, 32'hB);
    chk("lsb_first_bits", 1, {28'd0, cap[1][3:0]}, 32'hD);

    // Back-to-back words with load_valid held.
    cap[2] = '0; maxrun2 = 0;
    lv[2] = 1'b1; pin[2] = 8'hA5;
    tick();
    pin[2] = 8'h3C;
    repeat (7) tick();
    #1;
    chk("b2b_last_at_accept",  2, {31'd0, lst[2]}, 32'd1);
    chk("b2b_ready_at_accept", 2, {31'd0, rdy[2]}, 32'd1);
    tick();
    lv[2] = 1'b0; pin[2] = $urandom;
    repeat (8) tick();
    tick();
    chk("b2b_bits",      2, {16'd0, cap[2][15:0]}, 32'hA53C);
    chk("b2b_valid_run", 2, maxrun2, 32'd16);

    // Stall after the second bit with a load offered.
    cap[0] = '0;
    lv[0] = 1'b1; pin[0] = 8'h0C;
    tick();
    lv[0] = 1'b0;
    tick();
    tick();
    se[0] = 1'b0; lv[0] = 1'b1;
    repeat (3) begin
      pin[0] = $urandom;
      #1;
      chk("stall_out",   0, {31'd0, so[0]},  32'd0);
      chk("stall_ready", 0, {31'd0, rdy[0]}, 32'd0);
      tick();
    end
    lv[0] = 1'b0; se[0] = 1'b1;
    repeat (2) tick();
    tick();
    chk("stall_bits", 0, {28'd0, cap[0][3:0]}, 32'hC);

    // Asynchronous reset in the middle of a word.
    lv[2] = 1'b1; pin[2] = 8'hFF;
    tick();
    lv[2] = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 2, {31'd0, sv[2]},  32'd0);
    chk("async_rst_out",   2, {31'd0, so[2]},  32'd0);
    chk("async_rst_last",  2, {31'd0, lst[2]}, 32'd0);
    chk("async_rst_ready", 2, {31'd0, rdy[2]}, 32'd1);
    model_reset();
    @(negedge clk);
    tick();
    rst = 1'b1;
    tick();
    cap[2] = '0;
    lv[2] = 1'b1; pin[2] = 8'h01;
    tick();
    lv[2] = 1'b0;
    repeat (8) tick();
    tick();
    chk("post_rst_bits", 2, {24'd0, cap[2][7:0]}, 32'h01);

    // Held load_valid with changing parallel_in while busy.
    cap[2] = '0;
    lv[2] = 1'b1; pin[2] = 8'h96;
    tick();
    for (int i = 0; i < 7; i++) begin
      pin[2] = $urandom;
      tick();
    end
    pin[2] = 8'h5A;
    tick();
    lv[2] = 1'b0; pin[2] = $urandom;
    repeat (8) tick();
    tick();
    chk("hold_first_word",  2, {24'd0, cap[2][15:8]}, 32'h96);
    chk("hold_second_word", 2, {24'd0, cap[2][7:0]},  32'h5A);

    // Randomised traffic on all instances.
    repeat (3000) begin
      for (int d = 0; d < 3; d++) begin
        lv[d]  = ($urandom_range(0, 2) != 0);
        se[d]  = ($urandom_range(0, 3) != 0);
        pin[d] = 8'($urandom);
      end
      tick();
    end
    for (int d = 0; d < 3; d++) begin
      lv[d] = 1'b0; se[d] = 1'b1;
    end
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
